// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: glitch-filtered start, mid-bit sampling, framing/overrun status.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic                 overrun_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] DELIVER = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY  = 3'd5;
`endif

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 armed;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_acc;
`ifdef UART_RX_PARITY_EN
    logic                 perr_acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            armed       <= 1'b0;
            shreg       <= '0;
            ferr_acc    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc    <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            overrun_err <= 1'b0;
            // Accept clears status; a DELIVER load below overrides this in the same clk.
            if (rx_valid && rx_ready) begin
                rx_valid  <= 1'b0;
                frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end

            case (state)
                IDLE: begin
                    if (rx_s) armed <= 1'b1;
                    if (armed && !rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: if (baud_tick) begin
                    if (tick_cnt == TICK_HALF) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state    <= DATA;
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            ferr_acc <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DATA: if (baud_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (baud_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        perr_acc <= rx_s ^ (^shreg) ^ parity_odd;
                        state    <= STOP;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`endif
                STOP: if (baud_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (!rx_s) ferr_acc <= 1'b1;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            armed   <= 1'b0;
                            state   <= DELIVER;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DELIVER: begin
                    if (!rx_valid || rx_ready) begin
                        rx_data   <= shreg;
                        frame_err <= ferr_acc;
                        rx_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err <= perr_acc;
`endif
                    end else begin
                        overrun_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
